// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: byte-writable control registers
// with a read-only ID word at index 0; one write and one read in flight.
module axil_reg_bank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int                    REG_COUNT   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h1C2A_0001,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    output logic [REG_COUNT-1:0]            reg_wr_pulse
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(REG_COUNT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [1:REG_COUNT-1];
    logic                  run;
    logic                  aw_held;
    logic                  w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  commit;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_hit;
    logic                  unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr, s_axil_araddr};

    // run keeps every ready low until the first edge after reset release
    assign s_axil_awready = run && !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = run && !w_held && !s_axil_bvalid;
    assign s_axil_arready = run && !s_axil_rvalid;
    assign commit         = aw_held && w_held && !s_axil_bvalid;
    assign ar_idx         = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run           <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            run <= 1'b1;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (aw_idx < IDX_LIM) ? RESP_OKAY
                                                    : RESP_SLVERR;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs[i] <= RESET_VALUE;
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            for (int i = 1; i < REG_COUNT; i++) begin
                if (commit && aw_idx == IDX_W'(i)) begin
                    reg_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb[b]) begin
                            regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        if (ar_idx == '0) begin
            rd_word = ID_VALUE;
            rd_hit  = 1'b1;
        end
        for (int i = 1; i < REG_COUNT; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = regs[i];
                rd_hit  = 1'b1;
            end
        end
    end

    // the read samples regs before any commit on the same edge lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    assign reg_out[0 +: DATA_WIDTH] = ID_VALUE;
    for (genvar g = 1; g < REG_COUNT; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Randomized bench for axil_reg_bank against a word-array model,
// with a per-cycle compare of reg_out and reg_wr_pulse.
module tb_axil_reg_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [15:0]  araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_pulse;

    logic [31:0]  model [16];
    logic [15:0]  exp_pulse = '0;
    bit           chk_en = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  got;

    axil_reg_bank dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
        .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32],
                    (i == 0) ? 32'h1C2A0001 : model[i]);
            chk("reg_wr_pulse", reg_wr_pulse, exp_pulse);
        end
    end

    task automatic do_reset();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_pulse = '0;
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_awready", awready, 0);
        chk("rst_hold_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);
        chk("rel_bresp", bresp, 0);
        chk("rel_rresp", rresp, 0);
        chk("rel_rdata", rdata, 0);
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly);
        int cyc = 0;
        int idx;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        logic [1:0] eresp;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid = !w_done && cyc >= w_dly;
            if (aw_done) chk("awready_held", awready, 0);
            if (w_done) chk("wready_held", wready, 0);
            aw_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done |= aw_hs;
            w_done |= w_hs;
            cyc++;
            if (cyc > 40) begin
                chk("write_handshake_timeout", 0, 1);
                awvalid = 1'b0; wvalid = 1'b0;
                return;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_early", bvalid, 0);
        @(posedge clk);
        #1;
        idx = int'(addr >> 2);
        eresp = 2'b00;
        if (idx >= 16) begin
            eresp = 2'b10;
        end else if (idx != 0) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse[idx] = 1'b1;
        end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, eresp);
        for (int i = 0; i < b_dly; i++) begin
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, eresp);
            chk("awready_bwait", awready, 0);
            chk("wready_bwait", wready, 0);
            @(posedge clk);
            #1;
            exp_pulse = '0;
        end
        bready = 1'b1;
        chk("awready_bwait", awready, 0);
        chk("wready_bwait", wready, 0);
        @(posedge clk);
        #1;
        exp_pulse = '0;
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("awready_after_b", awready, 1);
        chk("wready_after_b", wready, 1);
    endtask

    task automatic axi_read(input logic [15:0] addr, input int ar_dly,
                            input int r_dly, output logic [31:0] val);
        int cyc = 0;
        int idx;
        bit hs = 0;
        logic [31:0] ed = '0;
        logic [1:0] er = 2'b00;
        val = '0;
        araddr = addr;
        idx = int'(addr >> 2);
        while (!hs) begin
            arvalid = cyc >= ar_dly;
            #1;
            if (arvalid && arready) begin
                hs = 1;
                if (idx == 0) ed = 32'h1C2A0001;
                else if (idx < 16) ed = model[idx];
                else begin ed = '0; er = 2'b10; end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!hs && cyc > 40) begin
                chk("read_handshake_timeout", 0, 1);
                arvalid = 1'b0;
                return;
            end
        end
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        val = rdata;
        for (int i = 0; i < r_dly; i++) begin
            chk("arready_rwait", arready, 0);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, ed);
            chk("rresp_hold", rresp, er);
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        chk("rvalid_clear", rvalid, 0);
        chk("arready_after_r", arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g2;
        #6;
        do_reset();
        chk_en = 1'b1;

        axi_read(16'h0000, 0, 0, got);
        chk("lit_id", got, 32'h1C2A0001);
        axi_read(16'h0014, 0, 0, got);
        chk("lit_idx5_reset", got, 32'h0);

        axi_write(16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_read(16'h0008, 0, 0, got);
        chk("lit_deadbeef", got, 32'hDEADBEEF);

        axi_write(16'h0008, 32'h11223344, 4'b0101, 2, 0, 0);
        axi_read(16'h000A, 0, 0, got);
        chk("lit_strb_merge", got, 32'hDE22BE44);

        axi_write(16'h0000, 32'h12345678, 4'hF, 0, 1, 0);
        axi_write(16'h0040, 32'h87654321, 4'hF, 1, 0, 0);
        axi_read(16'h0040, 0, 0, got);
        chk("lit_oor_rdata", got, 32'h0);

        axi_write(16'h0018, 32'h55AA55AA, 4'h0, 0, 0, 0);
        chk("lit_zero_strb", model[6], 32'h0);

        fork
            axi_write(16'h000C, 32'h0BADF00D, 4'hF, 0, 0, 5);
            axi_read(16'h0008, 0, 5, g2);
        join
        chk("lit_bp_read", g2, 32'hDE22BE44);

        fork
            axi_write(16'h0010, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
            axi_read(16'h0010, 1, 0, g2);
        join
        chk("lit_pre_write_read", g2, 32'h0);
        axi_read(16'h0010, 0, 0, got);
        chk("lit_post_write_read", got, 32'hA5A5A5A5);

        awaddr = 16'h000C;
        awvalid = 1'b1;
        #1;
        chk("aw_accept_before_rst", awready, 1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("no_bvalid_after_rst", bvalid, 0);
            @(posedge clk);
            #1;
        end
        axi_write(16'h000C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        axi_read(16'h000C, 0, 0, got);
        chk("lit_after_rst", got, 32'hCAFEF00D);

        for (int n = 0; n < 80; n++) begin
            logic [15:0] wa, ra;
            int op;
            wa = 16'($urandom_range(0, 16'h4F));
            ra = 16'($urandom_range(0, 16'h4F));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            end else if (op == 1) begin
                axi_read(ra, $urandom_range(0, 2), $urandom_range(0, 2), got);
            end else begin
                fork
                    axi_write(wa, $urandom, 4'($urandom),
                              $urandom_range(0, 2), $urandom_range(0, 2),
                              $urandom_range(0, 2));
                    axi_read(ra, $urandom_range(0, 3),
                             $urandom_range(0, 2), g2);
                join
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
